// File: rtl/trap_controller_if.sv
// CSR write port and fetch redirect between the trap controller and the rest of the core.
// CSR write: a write transfers on a rising edge where csr_we && csr_wready; while csr_we is high
// and csr_wready is low, csr_waddr/csr_wdata are held stable. redirect_valid is a one-cycle strobe
// with no ready; redirect_pc is meaningful only while it is high.
interface trap_controller_if #(
  parameter int XLEN = 64
);
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc,
    input  csr_wready
  );

  modport slave (
    input  csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc,
    output csr_wready
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: saves mepc then mcause through the CSR write port,
// flushes the pipeline and redirects fetch to mtvec; on mret redirects fetch to mepc.
module trap_controller #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exception_in,
  input  logic [XLEN-1:0] exception_pc_in,
  input  logic [3:0]      exception_cause_in,
  input  logic            mret_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  trap_controller_if.master bus,
  output logic            pipeline_flush,
  output logic            busy,
  output logic            nested_fault,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_EPC   = 3'd1,
    SAVE_CAUSE = 3'd2,
    TRAP_REDIR = 3'd3,
    MRET_REDIR = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [3:0]      cause_q, cause_d;
  logic            nested_d;

  always_comb begin
    state_d  = state;
    epc_d    = epc_q;
    cause_d  = cause_q;
    nested_d = nested_fault;
    case (state)
      IDLE: begin
        if (exception_in) begin
          state_d = SAVE_EPC;
          epc_d   = exception_pc_in;
          cause_d = exception_cause_in;
        end else if (mret_in) begin
          state_d = MRET_REDIR;
        end
      end
      SAVE_EPC:   if (bus.csr_wready) state_d = SAVE_CAUSE;
      SAVE_CAUSE: if (bus.csr_wready) state_d = TRAP_REDIR;
      TRAP_REDIR: state_d = IDLE;
      MRET_REDIR: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    // A second exception while a sequence is in flight is dropped but remembered.
    if (state != IDLE && exception_in) nested_d = 1'b1;
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      epc_q              <= '0;
      cause_q            <= '0;
      nested_fault       <= 1'b0;
      bus.csr_we         <= 1'b0;
      bus.csr_waddr      <= '0;
      bus.csr_wdata      <= '0;
      bus.redirect_valid <= 1'b0;
      pipeline_flush     <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state        <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      nested_fault <= nested_d;
      case (state_d)
        SAVE_EPC: begin
          bus.csr_we    <= 1'b1;
          bus.csr_waddr <= 12'h341;
          bus.csr_wdata <= {epc_d[XLEN-1:2], 2'b00};
        end
        SAVE_CAUSE: begin
          bus.csr_we    <= 1'b1;
          bus.csr_waddr <= 12'h342;
          bus.csr_wdata <= {{(XLEN-4){1'b0}}, cause_d};
        end
        default: begin
          bus.csr_we    <= 1'b0;
          bus.csr_waddr <= '0;
          bus.csr_wdata <= '0;
        end
      endcase
      bus.redirect_valid <= (state_d == TRAP_REDIR) || (state_d == MRET_REDIR);
      pipeline_flush     <= (state_d == SAVE_EPC) || (state_d == SAVE_CAUSE) ||
                            (state_d == TRAP_REDIR);
      busy               <= (state_d != IDLE);
    end
  end

  // Redirect targets follow the live CSR values during the redirect cycle itself.
  always_comb begin
    case (state)
      TRAP_REDIR: bus.redirect_pc = {mtvec_in[XLEN-1:2], 2'b00};
      MRET_REDIR: bus.redirect_pc = {mepc_in[XLEN-1:1], 1'b0};
      default:    bus.redirect_pc = '0;
    endcase
  end

  assign dbg_state = state;

  logic unused_bits;
  assign unused_bits = ^{mtvec_in[1:0], mepc_in[0], epc_q[1:0]};

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: CSR writes and redirects go through an expected queue,
// cycle-level behaviour (flush window, stalls, nested fault, reset) is checked inline.
module tb_trap_controller;
  localparam int XLEN = 64;
  localparam logic [2:0] S_IDLE = 3'd0, S_EPC = 3'd1, S_CAUSE = 3'd2, S_TRAP = 3'd3,
                         S_MRET = 3'd4;

  logic            clk = 1'b0;
  logic            reset;
  logic            exception_in;
  logic [XLEN-1:0] exception_pc_in;
  logic [3:0]      exception_cause_in;
  logic            mret_in;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic            pipeline_flush, busy, nested_fault;
  logic [2:0]      dbg_state;

  trap_controller_if #(.XLEN(XLEN)) bus ();

  trap_controller #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .reset              (reset),
    .exception_in       (exception_in),
    .exception_pc_in    (exception_pc_in),
    .exception_cause_in (exception_cause_in),
    .mret_in            (mret_in),
    .mtvec_in           (mtvec_in),
    .mepc_in            (mepc_in),
    .bus                (bus),
    .pipeline_flush     (pipeline_flush),
    .busy               (busy),
    .nested_fault       (nested_fault),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event encoding: {kind, addr, data}; kind 0 = accepted CSR write, 1 = redirect.
  localparam int EW = 1 + 12 + XLEN;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_write(input logic [11:0] addr, input logic [XLEN-1:0] data);
    exp_q.push_back({1'b0, addr, data});
  endtask

  task automatic exp_redir(input logic [XLEN-1:0] pc);
    exp_q.push_back({1'b1, 12'h000, pc});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got, want;
    if (!reset && bus.csr_we && bus.csr_wready) begin
      got = {1'b0, bus.csr_waddr, bus.csr_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_csr_write actual=%0h expected=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL csr_write actual=%0h expected=%0h", got, want);
        end
      end
    end
    if (!reset && bus.redirect_valid) begin
      got = {1'b1, 12'h000, bus.redirect_pc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect actual=%0h expected=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL redirect actual=%0h expected=%0h", got, want);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic chk_cycle(input string tag, input logic [2:0] st, input logic fl,
                           input logic rv, input logic we);
    mid();
    chk({tag, "_state"}, XLEN'(dbg_state), XLEN'(st));
    chk({tag, "_flush"}, XLEN'(pipeline_flush), XLEN'(fl));
    chk({tag, "_redirect_valid"}, XLEN'(bus.redirect_valid), XLEN'(rv));
    chk({tag, "_csr_we"}, XLEN'(bus.csr_we), XLEN'(we));
    chk({tag, "_busy"}, XLEN'(busy), XLEN'(st != S_IDLE));
  endtask

  task automatic raise_exc(input logic [XLEN-1:0] pc, input logic [3:0] cause);
    exception_in       = 1'b1;
    exception_pc_in    = pc;
    exception_cause_in = cause;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; exception_in = 1'b0; exception_pc_in = '0; exception_cause_in = '0;
    mret_in = 1'b0; mtvec_in = '0; mepc_in = '0; bus.csr_wready = 1'b1;
    step(); step();
    mid();
    chk("rst_csr_we", XLEN'(bus.csr_we), '0);
    chk("rst_csr_waddr", XLEN'(bus.csr_waddr), '0);
    chk("rst_csr_wdata", bus.csr_wdata, '0);
    chk("rst_flush", XLEN'(pipeline_flush), '0);
    chk("rst_redirect_valid", XLEN'(bus.redirect_valid), '0);
    chk("rst_redirect_pc", bus.redirect_pc, '0);
    chk("rst_busy", XLEN'(busy), '0);
    chk("rst_nested", XLEN'(nested_fault), '0);
    step();
    reset = 1'b0;
    step();

    // Basic trap, no backpressure.
    exp_write(12'h341, 64'h8000_0104);
    exp_write(12'h342, 64'h2);
    exp_redir(64'h8000_0000);
    mtvec_in = 64'h8000_0003;
    raise_exc(64'h8000_0104, 4'd2);
    step();                      // edge N
    exception_in = 1'b0;
    chk_cycle("t1_n1", S_EPC, 1, 0, 1);
    chk("t1_n1_waddr", XLEN'(bus.csr_waddr), 64'h341);
    step();
    chk_cycle("t1_n2", S_CAUSE, 1, 0, 1);
    chk("t1_n2_waddr", XLEN'(bus.csr_waddr), 64'h342);
    step();
    chk_cycle("t1_n3", S_TRAP, 1, 1, 0);
    step();
    chk_cycle("t1_n4", S_IDLE, 0, 0, 0);
    step();

    // Backpressure: 3 stall cycles in SAVE_EPC, 2 in SAVE_CAUSE.
    exp_write(12'h341, 64'h1000_2004);
    exp_write(12'h342, 64'h7);
    exp_redir(64'h4000_0100);
    mtvec_in = 64'h4000_0101;
    raise_exc(64'h1000_2007, 4'd7);
    step();                      // edge N
    exception_in = 1'b0;
    bus.csr_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_cycle("t2_epc_stall", S_EPC, 1, 0, 1);
      chk("t2_epc_waddr", XLEN'(bus.csr_waddr), 64'h341);
      chk("t2_epc_wdata", bus.csr_wdata, 64'h1000_2004);
      step();
    end
    bus.csr_wready = 1'b1;
    chk_cycle("t2_epc_go", S_EPC, 1, 0, 1);
    step();
    bus.csr_wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_cycle("t2_cause_stall", S_CAUSE, 1, 0, 1);
      chk("t2_cause_waddr", XLEN'(bus.csr_waddr), 64'h342);
      chk("t2_cause_wdata", bus.csr_wdata, 64'h7);
      step();
    end
    bus.csr_wready = 1'b1;
    chk_cycle("t2_cause_go", S_CAUSE, 1, 0, 1);
    step();
    chk_cycle("t2_n8", S_TRAP, 1, 1, 0);
    step();
    chk_cycle("t2_n9", S_IDLE, 0, 0, 0);
    step();

    // mret; mepc changes after entry and must be sampled in the redirect cycle.
    exp_redir(64'h8000_0200);
    mepc_in = 64'h0;
    mret_in = 1'b1;
    step();                      // edge N
    mret_in = 1'b0;
    mepc_in = 64'h8000_0201;
    chk_cycle("t3_n1", S_MRET, 0, 1, 0);
    step();
    chk_cycle("t3_n2", S_IDLE, 0, 0, 0);
    step();

    // Simultaneous exception and mret: exception wins.
    exp_write(12'h341, 64'h100);
    exp_write(12'h342, 64'hB);
    exp_redir(64'h200);
    mtvec_in = 64'h200;
    raise_exc(64'h100, 4'd11);
    mret_in = 1'b1;
    step();
    exception_in = 1'b0;
    mret_in = 1'b0;
    chk_cycle("t4_n1", S_EPC, 1, 0, 1);
    step();
    chk_cycle("t4_n2", S_CAUSE, 1, 0, 1);
    step();
    chk_cycle("t4_n3", S_TRAP, 1, 1, 0);
    step();
    chk_cycle("t4_n4", S_IDLE, 0, 0, 0);
    step();

    // Nested fault during SAVE_CAUSE.
    exp_write(12'h341, 64'h300);
    exp_write(12'h342, 64'h5);
    exp_redir(64'h1000);
    mtvec_in = 64'h1000;
    raise_exc(64'h300, 4'd5);
    step();
    exception_in = 1'b0;
    chk_cycle("t5_n1", S_EPC, 1, 0, 1);
    step();
    raise_exc(64'h200, 4'd9);
    chk_cycle("t5_n2", S_CAUSE, 1, 0, 1);
    chk("t5_n2_nested", XLEN'(nested_fault), '0);
    step();
    exception_in = 1'b0;
    chk_cycle("t5_n3", S_TRAP, 1, 1, 0);
    chk("t5_n3_nested", XLEN'(nested_fault), 64'h1);
    step();
    chk_cycle("t5_n4", S_IDLE, 0, 0, 0);
    chk("t5_n4_nested", XLEN'(nested_fault), 64'h1);
    step(); step();
    mid();
    chk("t5_nested_sticky", XLEN'(nested_fault), 64'h1);
    step();

    // Reset in SAVE_CAUSE with csr_wready low, together with a new exception.
    exp_write(12'h341, 64'h400);
    raise_exc(64'h400, 4'd3);
    step();
    exception_in = 1'b0;
    chk_cycle("t6_n1", S_EPC, 1, 0, 1);
    step();
    bus.csr_wready = 1'b0;
    reset = 1'b1;
    raise_exc(64'h600, 4'd6);
    mid();
    chk("t6_n2_state", XLEN'(dbg_state), XLEN'(S_CAUSE));
    step();
    reset = 1'b0;
    exception_in = 1'b0;
    bus.csr_wready = 1'b1;
    chk_cycle("t6_after_rst", S_IDLE, 0, 0, 0);
    chk("t6_nested_cleared", XLEN'(nested_fault), '0);
    chk("t6_wdata", bus.csr_wdata, '0);
    step();
    chk_cycle("t6_after_rst2", S_IDLE, 0, 0, 0);
    step();

    // Trap after reset completes normally.
    exp_write(12'h341, 64'h500);
    exp_write(12'h342, 64'h1);
    exp_redir(64'h2000);
    mtvec_in = 64'h2002;
    raise_exc(64'h501, 4'd1);
    step();
    exception_in = 1'b0;
    chk_cycle("t7_n1", S_EPC, 1, 0, 1);
    step();
    chk_cycle("t7_n2", S_CAUSE, 1, 0, 1);
    step();
    chk_cycle("t7_n3", S_TRAP, 1, 1, 0);
    step();
    chk_cycle("t7_n4", S_IDLE, 0, 0, 0);
    step(); step();

    // ---------------- report ----------------
    chk("exp_q_drained", XLEN'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequences machine-mode trap entry and return for the RISC-V pipeline. It consumes the exception report from the writeback stage, latches the trapping PC and cause, and writes `mepc` then `mcause` through the single CSR write port. It holds the pipeline flushed throughout and issues one PC redirect to `mtvec`. It also redirects to `mepc` on `mret`.

## Interface
- `XLEN`, 64: datapath width; legal values are 32 and 64.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `exception_in`  in  1: exception retired by writeback; already qualified with flush upstream.
- `exception_pc_in`  in  XLEN: PC of the trapping instruction.
- `exception_cause_in`  in  4: exception code.
- `mret_in`  in  1: `mret` retired this cycle.
- `mtvec_in`  in  XLEN: current `mtvec` CSR value.
- `mepc_in`  in  XLEN: current `mepc` CSR value.
- `csr_we`  out  1: CSR write request.
- `csr_waddr`  out  12: CSR address.
- `csr_wdata`  out  XLEN: CSR write data.
- `csr_wready`  in  1: CSR file accepts the write this cycle.
- `pipeline_flush`  out  1: squash all in-flight instructions.
- `redirect_valid`  out  1: one-cycle fetch redirect strobe.
- `redirect_pc`  out  XLEN: redirect target.
- `busy`  out  1: controller is not in IDLE.
- `nested_fault`  out  1: sticky flag, set when an exception arrives while busy.

## Operation
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, TRAP_REDIR, MRET_REDIR. The state is registered; all outputs decode from registered state and latches.
- IDLE:
  - `exception_in`=1: latch `epc_q`←`exception_pc_in` and `cause_q`←`exception_cause_in`; go to SAVE_EPC.
  - Otherwise `mret_in`=1: go to MRET_REDIR.
  - Both asserted: the exception wins and `mret_in` is dropped.
- SAVE_EPC:
  - `csr_we`=1, `csr_waddr`=12'h341, `csr_wdata`=`epc_q` with bits [1:0] cleared.
  - Hold every output stable until `csr_wready`=1, then go to SAVE_CAUSE.
- SAVE_CAUSE:
  - `csr_we`=1, `csr_waddr`=12'h342.
  - `csr_wdata`: bit XLEN-1 = 0 (not an interrupt); bits [3:0]=`cause_q`; all other bits zero.
  - Hold until `csr_wready`=1, then go to TRAP_REDIR.
- TRAP_REDIR: `redirect_valid`=1 and `redirect_pc`={`mtvec_in`[XLEN-1:2],2'b00}. Direct mode only; the mode bits are ignored. Go to IDLE next cycle.
- MRET_REDIR: `redirect_valid`=1 and `redirect_pc`={`mepc_in`[XLEN-1:1],1'b0}. Go to IDLE next cycle. No CSR write is issued.
- `pipeline_flush`=1 in SAVE_EPC, SAVE_CAUSE and TRAP_REDIR. It is 0 in MRET_REDIR, because writeback already flushes on `mret`.
- `busy`=1 in every state other than IDLE.
- Outside its write states: `csr_we`=0, `csr_waddr`=0, `csr_wdata`=0. Outside the redirect states: `redirect_valid`=0, `redirect_pc`=0.
- `exception_in` or `mret_in` while busy:
  - The input is ignored; latches and state are unchanged.
  - An `exception_in` also sets `nested_fault`=1, which stays set until reset.

## Timing
- Reset values:
  - State IDLE; `epc_q`=0, `cause_q`=0.
  - Outputs `csr_we`=0, `csr_waddr`=0, `csr_wdata`=0, `pipeline_flush`=0, `redirect_valid`=0, `redirect_pc`=0, `busy`=0, `nested_fault`=0.
- Reset in any state: IDLE and all-zero outputs from the next edge. Any partially completed CSR sequence is abandoned with no further `csr_we`. Reset overrides a simultaneous `exception_in`.
- Trap latency, with `exception_in` sampled at edge N and `csr_wready` tied high:
  - Cycle N+1: SAVE_EPC.
  - Cycle N+2: SAVE_CAUSE.
  - Cycle N+3: TRAP_REDIR, `redirect_valid` high for exactly one cycle.
  - Cycle N+4: IDLE; a new `exception_in` is accepted at edge N+4.
- Each cycle of `csr_wready`=0 adds one cycle to the write state it occurs in.
- `mret` latency: redirect in cycle N+1, IDLE in cycle N+2.
- `mtvec_in` and `mepc_in` are sampled in the redirect cycle, not at entry.

## Test plan
- Trap, XLEN=64, `csr_wready`=1: `exception_pc_in`=0x8000_0104, cause 4'd2, `mtvec_in`=0x8000_0003.
  - Expect writes 0x341←0x8000_0104, then 0x342←0x2.
  - Expect `redirect_pc`=0x8000_0000 at N+3.
  - Expect `pipeline_flush` high for exactly cycles N+1..N+3.
- Backpressure: `csr_wready` low for 3 cycles in SAVE_EPC and 2 cycles in SAVE_CAUSE.
  - `csr_waddr` and `csr_wdata` stay stable while stalled.
  - Redirect occurs at N+8; exactly two accepted writes.
- `mret` with `mepc_in`=0x8000_0201: `redirect_pc`=0x8000_0200 at N+1; `csr_we` never asserts; `pipeline_flush` stays 0.
- Simultaneous `exception_in` and `mret_in` (cause 4'd11, PC 0x100): the trap sequence runs and the `mret` is dropped.
- Nested fault: second `exception_in` (PC 0x200) during SAVE_CAUSE.
  - `nested_fault`=1 next cycle and stays set.
  - The 0x342 write still carries the first cause.
  - The redirect occurs as normal; 0x200 is never written.
- Reset asserted in SAVE_CAUSE with `csr_wready`=0: next cycle `busy`=0 and `csr_we`=0, with no redirect. A trap issued after reset completes normally.
